cdb_broadcaster: RTL and testbench
==================================

Name: cdb_broadcaster

Overview:
- Transmit end of the Common Data Bus (CDB). It collects completed results (ROB tag plus value) from the functional units and buffers them per FU.
- Each cycle it round-robin arbitrates among the buffered results and drives at most one registered broadcast, cdb_packet_out.
- The RS wakeup logic, map table and ROB consume that broadcast.
- It sits between the execute stage and the complete stage and back-pressures the FUs when their buffers are full.

Parameters:
- NUM_FU, 4, number of functional-unit result ports.
- BUF_DEPTH, 2, result-buffer entries per FU (power of two, at least 2).
- XLEN, 32, result value width.
- TAG_W, $clog2(`ROB_LEN), ROB tag width. Tag 0 is reserved as "no tag / register file".

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- fu_valid  input  NUM_FU  FU i presents a result this cycle.
- fu_tag  input  NUM_FU x TAG_W  ROB tag of each FU result.
- fu_value  input  NUM_FU x XLEN  result value of each FU.
- fu_ready  output  NUM_FU  buffer i can accept a result this cycle.
- squash  input  1  ROB mispredict flush, synchronous.
- cdb_packet_out  output  CDB_PACKET  registered broadcast {reg_tag, reg_value}.
- cdb_valid  output  1  registered; the broadcast is meaningful this cycle.
- cdb_src  output  $clog2(NUM_FU)  registered index of the FU that was granted (debug).

Behaviour:
- Reset (reset=0), asynchronous and immediate with no clock edge needed:
  - cdb_valid=0, reg_tag=0, reg_value=0, cdb_src=0.
  - All buffers empty, round-robin pointer rr_ptr=0.
  - fu_ready is combinational: fu_ready[i] = reset & ~full[i]. It is therefore 0 while reset is asserted and 1 right after release.
- Enqueue:
  - At a posedge with fu_valid[i] & fu_ready[i] & (fu_tag[i]!=0) & ~squash, push {tag, value} into buffer i.
  - fu_valid[i] with tag 0 is ignored: no push and no error.
  - fu_ready does not see a same-cycle dequeue. A full buffer deasserts ready even if it is granted that cycle.
- Arbitration:
  - Uses the combinational nonempty vector, sampled before this edge's enqueue.
  - Grant goes to the first nonempty buffer searching from rr_ptr upward, wrapping modulo NUM_FU.
  - On a grant, rr_ptr <= (granted+1) mod NUM_FU. With no grant, rr_ptr is unchanged.
- Broadcast:
  - At each posedge, the output register loads the head of the granted buffer (cdb_valid=1, cdb_src=granted) and that entry is popped.
  - With no grant: cdb_valid=0, reg_tag=0, reg_value holds its previous value. Consumers qualify on cdb_valid or on reg_tag!=0.
  - Latency: a result accepted at edge N into an empty system appears on the CDB in the cycle after edge N+1 (one cycle of buffering). Throughput is one broadcast per cycle.
- Buffers:
  - Each is a circular FIFO with head/tail pointers that wrap at BUF_DEPTH and a count of width $clog2(BUF_DEPTH)+1.
  - Simultaneous push and pop on the same buffer: count unchanged, both pointers advance.
  - Pop on empty and push on full cannot occur by construction. An assertion checks both.
- Squash:
  - At a posedge with squash=1, all buffers are cleared, rr_ptr=0 and cdb_valid=0/reg_tag=0 next cycle.
  - Any same-cycle fu_valid is dropped.
  - The broadcast already on the bus during the squash cycle is not retracted.
- Ordering: results from one FU are broadcast in arrival order. There is no ordering guarantee across FUs.
- Reset mid-burst: all buffered results are lost. Upstream squash/reset logic owns recovery.

Decomposition:
- sys_defs package holds:
  - CDB_PACKET {reg_tag [TAG_W], reg_value [XLEN]}, shared with RS/MT/ROB.
  - FU2CDB_PACKET {valid, tag, value}.
  - `NUM_FU and `CDB_BUF_DEPTH.
- Natural sub-module: cdb_fu_fifo, one per FU. It has push/pop/flush, head data, full/empty, and async active-low reset.
- The arbiter and output register stay in the top level.

Test Plan:
1. Reset: hold reset=0 for 2 cycles, then raise it. -> During reset fu_ready=0000, cdb_valid=0, reg_tag=0, reg_value=0. After release fu_ready=1111.
2. Single result: FU0 presents tag 3, value 20 for one cycle. -> The next cycle shows cdb_valid=1, reg_tag=3, reg_value=20, cdb_src=0 for exactly one cycle, then cdb_valid=0.
3. Four-way collision: FU0..FU3 present tags 1,2,3,4 (values 10,20,30,40) in the same cycle. -> Broadcasts tag 1,2,3,4 on four consecutive cycles with cdb_src 0,1,2,3.
4. Saturation and fairness: all FUs hold fu_valid=1 continuously with unique tags. -> fu_ready deasserts once buffers fill. Each FU is granted exactly once in every 4-cycle window. No tag is lost or duplicated; the scoreboard checks this.
5. Squash: buffer 3 results across FU1/FU2, then pulse squash while FU0 offers tag 7. -> The next cycle cdb_valid=0, fu_ready=1111, tag 7 is never broadcast and no stale tag appears afterwards.
6. Tag-0 and async reset: FU2 offers tag 0, value 99 -> never broadcast. Then drop reset mid-cycle during a burst -> cdb_valid falls immediately, before the next edge.

Source files
------------

// File: rtl/sys_defs.sv
// Shared definitions for the CDB and its consumers (RS wakeup, map table, ROB).
// CDB_PACKET   : broadcast payload {reg_tag, reg_value}; tag 0 means "no tag".
// FU2CDB_PACKET: one functional-unit result as presented to the broadcaster.
package sys_defs;

    localparam int unsigned ROB_LEN       = 32;
    localparam int unsigned XLEN          = 32;
    localparam int unsigned TAG_W         = $clog2(ROB_LEN);
    localparam int unsigned NUM_FU        = 4;
    localparam int unsigned CDB_BUF_DEPTH = 2;

    typedef struct packed {
        logic [TAG_W-1:0] reg_tag;
        logic [XLEN-1:0]  reg_value;
    } CDB_PACKET;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
    } FU2CDB_PACKET;

endpackage

// File: rtl/cdb_fu_fifo.sv
// Per-FU result buffer: circular FIFO of CDB packets.
// Ports: clk, rst_n (async active-low), push_i/push_data_i, pop_i, flush_i
//        (synchronous clear, dominates push/pop), head_o (oldest entry),
//        full_o/empty_o (decoded from the registered occupancy count).
module cdb_fu_fifo
    import sys_defs::CDB_PACKET;
#(
    parameter int unsigned DEPTH = sys_defs::CDB_BUF_DEPTH
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  CDB_PACKET push_data_i,
    input  logic      pop_i,
    input  logic      flush_i,
    output CDB_PACKET head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    CDB_PACKET          mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Pointer/count update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) tail_d = tail_q + PTR_W'(1);
            if (pop_i)  head_d = head_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read when count_q says valid.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[tail_q] <= push_data_i;
    end

    assign head_o  = mem_q[head_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_o));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop_i && empty_o));

endmodule

// File: rtl/cdb_broadcaster.sv
// Transmit end of the Common Data Bus: buffers FU results per FU, round-robin
// arbitrates among nonempty buffers and drives one registered broadcast/cycle.
// Ports: clock, reset (async active-low), fu_valid/fu_tag/fu_value (FU results),
//        fu_ready (combinational back-pressure), squash (sync flush),
//        cdb_packet_out/cdb_valid/cdb_src (registered broadcast and grant index).
module cdb_broadcaster
    import sys_defs::CDB_PACKET;
    import sys_defs::FU2CDB_PACKET;
    import sys_defs::TAG_W;
    import sys_defs::XLEN;
#(
    parameter int unsigned NUM_FU    = sys_defs::NUM_FU,
    parameter int unsigned BUF_DEPTH = sys_defs::CDB_BUF_DEPTH
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_FU-1:0]                fu_valid,
    input  logic [NUM_FU-1:0][TAG_W-1:0]     fu_tag,
    input  logic [NUM_FU-1:0][XLEN-1:0]      fu_value,
    output logic [NUM_FU-1:0]                fu_ready,
    input  logic                             squash,
    output CDB_PACKET                        cdb_packet_out,
    output logic                             cdb_valid,
    output logic [$clog2(NUM_FU)-1:0]        cdb_src
);

    localparam int unsigned SRC_W = $clog2(NUM_FU);

    logic [NUM_FU-1:0] full, empty, push, pop;
    CDB_PACKET         head [NUM_FU];

    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              valid_q, valid_d;
    CDB_PACKET         pkt_q, pkt_d;
    logic [SRC_W-1:0]  src_q, src_d;

    logic              grant_vld;
    logic [SRC_W-1:0]  grant_idx;
    int unsigned       idx;

    // Ready ignores a same-cycle pop so it never depends on the arbiter.
    assign fu_ready = {NUM_FU{reset}} & ~full;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
        FU2CDB_PACKET fu_in;
        CDB_PACKET    fu_pkt;

        assign fu_in   = {fu_valid[g], fu_tag[g], fu_value[g]};
        assign fu_pkt  = '{reg_tag: fu_in.tag, reg_value: fu_in.value};
        // Tag 0 is the "no tag" encoding and is silently dropped.
        assign push[g] = fu_in.valid & fu_ready[g] & (fu_in.tag != '0) & ~squash;

        cdb_fu_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
            .clk         (clock),
            .rst_n       (reset),
            .push_i      (push[g]),
            .push_data_i (fu_pkt),
            .pop_i       (pop[g]),
            .flush_i     (squash),
            .head_o      (head[g]),
            .full_o      (full[g]),
            .empty_o     (empty[g])
        );
    end

    // Round-robin search: first nonempty buffer at or above rr_ptr, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_FU) idx = idx - NUM_FU;
            if (!grant_vld && !empty[SRC_W'(idx)]) begin
                grant_vld = 1'b1;
                grant_idx = SRC_W'(idx);
            end
        end
    end

    // Broadcast register next state; reg_value holds when idle.
    always_comb begin
        pop      = '0;
        valid_d  = 1'b0;
        pkt_d    = '{reg_tag: '0, reg_value: pkt_q.reg_value};
        src_d    = src_q;
        rr_ptr_d = rr_ptr_q;
        if (squash) begin
            rr_ptr_d = '0;
        end else if (grant_vld) begin
            pop[grant_idx] = 1'b1;
            valid_d        = 1'b1;
            pkt_d          = head[grant_idx];
            src_d          = grant_idx;
            rr_ptr_d       = (32'(grant_idx) == NUM_FU - 1) ? '0 : grant_idx + SRC_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            pkt_q    <= '0;
            src_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            valid_q  <= valid_d;
            pkt_q    <= pkt_d;
            src_q    <= src_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign cdb_valid      = valid_q;
    assign cdb_packet_out = pkt_q;
    assign cdb_src        = src_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Scoreboard bench for cdb_broadcaster: a queue-based reference model predicts
// each broadcast; a negedge monitor compares every DUT broadcast and fu_ready.
module tb_cdb_broadcaster;
    import sys_defs::*;

    localparam int NF = 4;
    localparam int BD = 2;

    logic                      clock;
    logic                      reset;
    logic [NF-1:0]             fu_valid;
    logic [NF-1:0][TAG_W-1:0]  fu_tag;
    logic [NF-1:0][XLEN-1:0]   fu_value;
    logic [NF-1:0]             fu_ready;
    logic                      squash;
    CDB_PACKET                 cdb_packet_out;
    logic                      cdb_valid;
    logic [1:0]                cdb_src;

    cdb_broadcaster #(.NUM_FU(NF), .BUF_DEPTH(BD)) dut (
        .clock          (clock),
        .reset          (reset),
        .fu_valid       (fu_valid),
        .fu_tag         (fu_tag),
        .fu_value       (fu_value),
        .fu_ready       (fu_ready),
        .squash         (squash),
        .cdb_packet_out (cdb_packet_out),
        .cdb_valid      (cdb_valid),
        .cdb_src        (cdb_src)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
    } ent_t;
    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
        int               src;
    } exp_t;

    ent_t mq [NF][$];
    exp_t exp_q [$];
    int   rr;

    int n_checks = 0;
    int n_errors = 0;

    logic sat_phase = 1'b0;
    logic sq_phase  = 1'b0;
    logic seen7     = 1'b0;
    int   src_hist [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: FIFOs per FU, rotating priority, one grant per edge.
    always @(posedge clock or negedge reset) begin
        logic    g;
        int      gi;
        logic    rdy [NF];
        ent_t    e;
        if (!reset) begin
            for (int i = 0; i < NF; i++) mq[i].delete();
            exp_q.delete();
            rr = 0;
        end else if (squash) begin
            for (int i = 0; i < NF; i++) mq[i].delete();
            rr = 0;
        end else begin
            g  = 1'b0;
            gi = 0;
            for (int i = 0; i < NF; i++) rdy[i] = (mq[i].size() < BD);
            for (int k = 0; k < NF; k++) begin
                if (!g && mq[(rr + k) % NF].size() > 0) begin
                    g  = 1'b1;
                    gi = (rr + k) % NF;
                end
            end
            if (g) begin
                e = mq[gi].pop_front();
                exp_q.push_back('{tag: e.tag, value: e.value, src: gi});
                rr = (gi + 1) % NF;
            end
            for (int i = 0; i < NF; i++) begin
                if (fu_valid[i] && rdy[i] && fu_tag[i] != 0)
                    mq[i].push_back('{tag: fu_tag[i], value: fu_value[i]});
            end
        end
    end

    // Monitor: compare every broadcast against the scoreboard and check ready.
    always @(negedge clock) begin
        logic [NF-1:0] rdy_exp;
        exp_t          x;
        if (reset) begin
            for (int i = 0; i < NF; i++) rdy_exp[i] = (mq[i].size() < BD);
            chk("fu_ready", 64'(fu_ready), 64'(rdy_exp));
            if (cdb_valid) begin
                if (sq_phase && cdb_packet_out.reg_tag == 7) seen7 = 1'b1;
                if (sat_phase) src_hist.push_back(int'(cdb_src));
                if (exp_q.size() == 0) begin
                    chk("unexpected_bcast_tag", 64'(cdb_packet_out.reg_tag), 64'(0));
                end else begin
                    x = exp_q.pop_front();
                    chk("bcast", {27'(0), cdb_packet_out.reg_tag, cdb_packet_out.reg_value},
                        {27'(0), x.tag, x.value});
                    chk("bcast_src", 64'(cdb_src), 64'(x.src));
                end
            end else begin
                chk("idle_tag", 64'(cdb_packet_out.reg_tag), 64'(0));
            end
        end
    end

    task automatic clear_in();
        fu_valid = '0;
        fu_tag   = '0;
        fu_value = '0;
        squash   = 1'b0;
    endtask

    task automatic set_fu(input int i, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v);
        fu_valid[i] = 1'b1;
        fu_tag[i]   = t;
        fu_value[i] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nt;
        int viol;
        reset = 1'b0;
        clear_in();

        // Reset behaviour
        repeat (2) @(negedge clock);
        chk("rst_ready", 64'(fu_ready), 64'(0));
        chk("rst_valid", 64'(cdb_valid), 64'(0));
        chk("rst_tag",   64'(cdb_packet_out.reg_tag), 64'(0));
        chk("rst_value", 64'(cdb_packet_out.reg_value), 64'(0));
        chk("rst_src",   64'(cdb_src), 64'(0));
        reset = 1'b1;
        #1;
        chk("rel_ready", 64'(fu_ready), 64'hf);

        // Four-way collision from rr_ptr=0
        for (int i = 0; i < NF; i++) set_fu(i, TAG_W'(i + 1), XLEN'(10 * (i + 1)));
        @(negedge clock); clear_in();
        for (int k = 0; k < NF; k++) begin
            @(negedge clock);
            chk("coll_valid", 64'(cdb_valid), 64'(1));
            chk("coll_tag",   64'(cdb_packet_out.reg_tag), 64'(k + 1));
            chk("coll_value", 64'(cdb_packet_out.reg_value), 64'(10 * (k + 1)));
            chk("coll_src",   64'(cdb_src), 64'(k));
        end
        @(negedge clock);
        chk("coll_done", 64'(cdb_valid), 64'(0));

        // Single result, one-cycle buffering latency
        set_fu(0, TAG_W'(3), XLEN'(20));
        @(negedge clock); clear_in();
        chk("single_early", 64'(cdb_valid), 64'(0));
        @(negedge clock);
        chk("single_valid", 64'(cdb_valid), 64'(1));
        chk("single_tag",   64'(cdb_packet_out.reg_tag), 64'(3));
        chk("single_value", 64'(cdb_packet_out.reg_value), 64'(20));
        chk("single_src",   64'(cdb_src), 64'(0));
        @(negedge clock);
        chk("single_once", 64'(cdb_valid), 64'(0));

        // Saturation and fairness
        nt = 1;
        viol = 0;
        sat_phase = 1'b1;
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < NF; i++) begin
                set_fu(i, TAG_W'(nt), XLEN'($urandom));
                nt = (nt == 31) ? 1 : nt + 1;
            end
            @(negedge clock);
        end
        sat_phase = 1'b0;
        chk("sat_backpressure", 64'(fu_ready != 4'hf), 64'(1));
        clear_in();
        for (int k = 1; k < src_hist.size(); k++)
            if (src_hist[k] != (src_hist[k-1] + 1) % NF) viol++;
        chk("sat_fairness", 64'(viol), 64'(0));
        chk("sat_grants", 64'(src_hist.size() >= 36), 64'(1));
        repeat (12) @(negedge clock);

        // Squash with buffered results and a same-cycle offer of tag 7
        sq_phase = 1'b1;
        set_fu(1, TAG_W'(5), XLEN'(55));
        set_fu(2, TAG_W'(6), XLEN'(66));
        @(negedge clock); clear_in();
        set_fu(1, TAG_W'(8), XLEN'(88));
        set_fu(2, TAG_W'(9), XLEN'(99));
        @(negedge clock); clear_in();
        set_fu(0, TAG_W'(7), XLEN'(77));
        squash = 1'b1;
        @(negedge clock); clear_in();
        chk("sq_valid", 64'(cdb_valid), 64'(0));
        chk("sq_ready", 64'(fu_ready), 64'hf);
        repeat (6) @(negedge clock);
        chk("sq_no_tag7", 64'(seen7), 64'(0));
        sq_phase = 1'b0;

        // Tag 0 is never broadcast
        set_fu(2, TAG_W'(0), XLEN'(99));
        @(negedge clock); clear_in();
        @(negedge clock);
        chk("tag0_none", 64'(cdb_valid), 64'(0));
        @(negedge clock);
        chk("tag0_none2", 64'(cdb_valid), 64'(0));

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < NF; i++) set_fu(i, TAG_W'(11 + i), XLEN'($urandom));
        @(negedge clock); clear_in();
        @(negedge clock);
        chk("burst_running", 64'(cdb_valid), 64'(1));
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", 64'(cdb_valid), 64'(0));
        chk("arst_tag",   64'(cdb_packet_out.reg_tag), 64'(0));
        chk("arst_ready", 64'(fu_ready), 64'(0));
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("arst_lost", 64'(cdb_valid), 64'(0));

        // Randomized traffic with occasional squash and tag-0 offers
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NF; i++) begin
                fu_valid[i] = 1'($urandom);
                fu_tag[i]   = TAG_W'($urandom_range(0, 31));
                fu_value[i] = XLEN'($urandom);
            end
            squash = ($urandom_range(0, 29) == 0);
            @(negedge clock);
        end
        clear_in();
        repeat (20) @(negedge clock);
        chk("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
